// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults for the multi-port register file: data and
//               address widths and the index of the hardwired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_IDX = 0;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp_if
// Description : Read/write/scoreboard bus of the multi-port register file.
//               master = pipeline side (decode/writeback), slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_mp_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set_en, sb_set_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set_en, sb_set_addr,
    output rd_data, rd_busy
  );

endinterface : reg_file_mp_if
`default_nettype wire

// File: rtl/reg_file_mp_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational read port: storage mux, optional same-cycle
//               write forwarding, busy lookup and zero-register override.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic                                i_rst_n,
  input  wire logic [ADDR_W-1:0]                   i_addr,
  input  wire logic [(2**ADDR_W)-1:0][DATA_W-1:0]  i_regs,
  input  wire logic [(2**ADDR_W)-1:0]              i_busy,
  input  wire logic                                i_wa_en,
  input  wire logic [ADDR_W-1:0]                   i_wa_addr,
  input  wire logic [DATA_W-1:0]                   i_wa_data,
  input  wire logic                                i_wb_en,
  input  wire logic [ADDR_W-1:0]                   i_wb_addr,
  input  wire logic [DATA_W-1:0]                   i_wb_data,
  input  wire logic                                i_sb_set_en,
  input  wire logic [ADDR_W-1:0]                   i_sb_set_addr,
  output logic      [DATA_W-1:0]                   o_data,
  output logic                                     o_busy
);

  logic w_is_zero;
  logic w_wa_hit;
  logic w_wb_hit;
  logic w_set_hit;

  assign w_is_zero = (ZERO_REG != 0) && (i_addr == ADDR_W'(RF_ZERO_IDX));
  assign w_wa_hit  = i_wa_en && (i_wa_addr == i_addr);
  assign w_wb_hit  = i_wb_en && (i_wb_addr == i_addr);
  assign w_set_hit = i_sb_set_en && (i_sb_set_addr == i_addr);

  // Select stored/forwarded data and busy; zero register and reset force zero
  always_comb begin
    o_data = i_regs[i_addr];
    o_busy = i_busy[i_addr];
    if (BYPASS != 0) begin
      // Port A has priority, matching the write-collision rule of the storage
      if (w_wa_hit) begin
        o_data = i_wa_data;
      end else if (w_wb_hit) begin
        o_data = i_wb_data;
      end
      // A load writeback retires the pending mark in the same cycle, unless a
      // new load to the same register is being issued at the same time
      if (w_wb_hit && !w_set_hit) begin
        o_busy = 1'b0;
      end
    end
    if (w_is_zero || !i_rst_n) begin
      o_data = '0;
      o_busy = 1'b0;
    end
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-port register file with two write ports
//               (ALU / load writeback), hardwired zero register, write-to-read
//               bypass and a per-register busy scoreboard. Flop storage.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input wire logic      clk,
  input wire logic      rst_n,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(RF_ZERO_IDX);

  logic [DEPTH-1:0][DATA_W-1:0]  r_regs;
  logic [DEPTH-1:0]              r_busy;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]             w_rd_busy;
  logic                          w_wa_ok;
  logic                          w_wb_ok;
  logic                          w_set_ok;

  // Writes and scoreboard updates aimed at the zero register are dropped
  assign w_wa_ok  = bus.wa_en     && !((ZERO_REG != 0) && (bus.wa_addr     == C_ZERO_ADDR));
  assign w_wb_ok  = bus.wb_en     && !((ZERO_REG != 0) && (bus.wb_addr     == C_ZERO_ADDR));
  assign w_set_ok = bus.sb_set_en && !((ZERO_REG != 0) && (bus.sb_set_addr == C_ZERO_ADDR));

  // Register storage: port B first so port A wins an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      if (w_wb_ok) begin
        r_regs[bus.wb_addr] <= bus.wb_data;
      end
      if (w_wa_ok) begin
        r_regs[bus.wa_addr] <= bus.wa_data;
      end
    end
  end

  // Busy scoreboard: clear on load writeback, then set on load issue (set wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (w_wb_ok) begin
        r_busy[bus.wb_addr] <= 1'b0;
      end
      if (w_set_ok) begin
        r_busy[bus.sb_set_addr] <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
      rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_rd_port (
        .i_rst_n       (rst_n),
        .i_addr        (bus.rd_addr[gi*ADDR_W +: ADDR_W]),
        .i_regs        (r_regs),
        .i_busy        (r_busy),
        .i_wa_en       (bus.wa_en),
        .i_wa_addr     (bus.wa_addr),
        .i_wa_data     (bus.wa_data),
        .i_wb_en       (bus.wb_en),
        .i_wb_addr     (bus.wb_addr),
        .i_wb_data     (bus.wb_data),
        .i_sb_set_en   (bus.sb_set_en),
        .i_sb_set_addr (bus.sb_set_addr),
        .o_data        (w_rd_data[gi]),
        .o_busy        (w_rd_busy[gi])
      );
    end
  endgenerate

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_rd_busy;

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp. Three instances: bypass
//               on and off (32x32, 2 ports) and a small 8x16, 3-port variant
//               exercised with random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  logic clk;
  logic rst_n;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();
  reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) ifc ();

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference model of the small instance
  logic [15:0] ref_c[8];
  logic        refb_c[8];

  task automatic exp(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] da(input int p);
    return ifa.rd_data[p*32 +: 32];
  endfunction
  function automatic logic [31:0] db(input int p);
    return ifb.rd_data[p*32 +: 32];
  endfunction
  function automatic logic [31:0] ba(input int p);
    return {31'b0, ifa.rd_busy[p]};
  endfunction
  function automatic logic [31:0] bb(input int p);
    return {31'b0, ifb.rd_busy[p]};
  endfunction
  function automatic logic [31:0] dc(input int p);
    return {16'b0, ifc.rd_data[p*16 +: 16]};
  endfunction
  function automatic logic [31:0] bc(input int p);
    return {31'b0, ifc.rd_busy[p]};
  endfunction

  // Same stimulus into the bypass and non-bypass instances
  task automatic drv(input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                     input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                     input logic sbe, input logic [4:0] sba);
    ifa.wa_en = wae; ifa.wa_addr = waa; ifa.wa_data = wad;
    ifa.wb_en = wbe; ifa.wb_addr = wba; ifa.wb_data = wbd;
    ifa.sb_set_en = sbe; ifa.sb_set_addr = sba;
    ifb.wa_en = wae; ifb.wa_addr = waa; ifb.wa_data = wad;
    ifb.wb_en = wbe; ifb.wb_addr = wba; ifb.wb_data = wbd;
    ifb.sb_set_en = sbe; ifb.sb_set_addr = sba;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    ifa.rd_addr = {a1, a0};
    ifb.rd_addr = {a1, a0};
  endtask

  task automatic idle_c();
    ifc.wa_en = 1'b0; ifc.wa_addr = '0; ifc.wa_data = '0;
    ifc.wb_en = 1'b0; ifc.wb_addr = '0; ifc.wb_data = '0;
    ifc.sb_set_en = 1'b0; ifc.sb_set_addr = '0;
    ifc.rd_addr = '0;
  endtask

  initial begin
    logic [2:0]  ra[3];
    logic [15:0] ed;
    logic        eb;

    // ---- reset: reads are zero while rst_n is low, even with a live write
    rst_n = 1'b0;
    drv(1'b1, 5'd5, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    rd(5'd5, 5'd9);
    idle_c();
    ifc.wa_en = 1'b1; ifc.wa_addr = 3'd2; ifc.wa_data = 16'hAAAA; ifc.rd_addr = {3'd2, 3'd2, 3'd2};
    @(negedge clk);
    exp("rst_a_data", 32'h0); exp("rst_a_busy", 32'h0);
    exp("rst_b_data", 32'h0); exp("rst_c_data", 32'h0);
    #1;
    chk(da(0)); chk(ba(1)); chk(db(0)); chk(dc(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle_c();

    // ---- write then reset mid-cycle: reads drop to zero at once
    @(negedge clk);
    drv(1'b1, 5'd5, 32'h000000AA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    rd(5'd5, 5'd9);
    @(negedge clk);
    idle();
    exp("pre_rst_a_data", 32'hAA); exp("pre_rst_a_busy", 32'h1);
    exp("pre_rst_b_data", 32'hAA); exp("pre_rst_b_busy", 32'h1);
    #1;
    chk(da(0)); chk(ba(1)); chk(db(0)); chk(bb(1));
    @(negedge clk);
    drv(1'b1, 5'd5, 32'h000000BB, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    rd(5'd5, 5'd4);
    #2 rst_n = 1'b0;
    exp("mid_rst_a_data", 32'h0); exp("mid_rst_a_busy", 32'h0);
    exp("mid_rst_b_data", 32'h0); exp("mid_rst_b_busy", 32'h0);
    #1;
    chk(da(0)); chk(ba(1)); chk(db(0)); chk(bb(1));
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    exp("post_rst_data", 32'h0); exp("post_rst_busy", 32'h0);
    #1;
    chk(da(0)); chk(ba(1));

    // ---- write A addr 5, read on port 1 in the same cycle
    @(negedge clk);
    drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd(5'd0, 5'd5);
    exp("byp_a_same", 32'hDEADBEEF); exp("nobyp_b_same", 32'h0);
    #1;
    chk(da(1)); chk(db(1));
    @(negedge clk);
    idle();
    exp("byp_a_next", 32'hDEADBEEF); exp("nobyp_b_next", 32'hDEADBEEF);
    #1;
    chk(da(1)); chk(db(1));

    // ---- A and B collide on addr 7: A wins
    @(negedge clk);
    drv(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    rd(5'd7, 5'd5);
    exp("coll_a_same", 32'h11); exp("coll_b_same", 32'h0);
    #1;
    chk(da(0)); chk(db(0));
    @(negedge clk);
    idle();
    exp("coll_a_next", 32'h11); exp("coll_b_next", 32'h11);
    #1;
    chk(da(0)); chk(db(0));

    // ---- zero register ignores writes and busy sets
    @(negedge clk);
    drv(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    rd(5'd0, 5'd0);
    exp("zero_a_same_d", 32'h0); exp("zero_a_same_b", 32'h0); exp("zero_b_same_d", 32'h0);
    #1;
    chk(da(0)); chk(ba(1)); chk(db(1));
    @(negedge clk);
    idle();
    exp("zero_a_next_d", 32'h0); exp("zero_a_next_b", 32'h0);
    exp("zero_b_next_d", 32'h0); exp("zero_b_next_b", 32'h0);
    #1;
    chk(da(0)); chk(ba(1)); chk(db(0)); chk(bb(1));

    // ---- scoreboard on addr 3
    @(negedge clk);
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    rd(5'd3, 5'd3);
    @(negedge clk);
    idle();
    exp("sb_set_a", 32'h1); exp("sb_set_b", 32'h1);
    #1;
    chk(ba(0)); chk(bb(0));
    @(negedge clk);
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
    exp("sb_clr_a_busy", 32'h0); exp("sb_clr_a_data", 32'h55);
    exp("sb_clr_b_busy", 32'h1); exp("sb_clr_b_data", 32'h0);
    #1;
    chk(ba(0)); chk(da(0)); chk(bb(0)); chk(db(0));
    @(negedge clk);
    idle();
    exp("sb_clr_a_next", 32'h0); exp("sb_clr_b_next", 32'h0); exp("sb_clr_b_data_next", 32'h55);
    #1;
    chk(ba(0)); chk(bb(0)); chk(db(1));
    // set, then set and clear together: busy stays 1
    @(negedge clk);
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    @(negedge clk);
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h66, 1'b1, 5'd3);
    exp("sb_both_a_same", 32'h1);
    #1;
    chk(ba(0));
    @(negedge clk);
    idle();
    exp("sb_both_a_next", 32'h1); exp("sb_both_b_next", 32'h1); exp("sb_both_data", 32'h66);
    #1;
    chk(ba(0)); chk(bb(0)); chk(da(1));
    // re-set on a busy register and a port A write: busy unchanged
    @(negedge clk);
    drv(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    @(negedge clk);
    drv(1'b1, 5'd3, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    idle();
    exp("sb_wa_keep_a", 32'h1); exp("sb_wa_keep_b", 32'h1); exp("sb_wa_data", 32'h88);
    #1;
    chk(ba(0)); chk(bb(1)); chk(db(0));
    // one writeback clears it despite the repeated set
    @(negedge clk);
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h99, 1'b0, 5'd0);
    @(negedge clk);
    idle();
    exp("sb_no_count", 32'h0);
    #1;
    chk(bb(0));

    // ---- small 3-port instance: random traffic against the model
    for (int i = 0; i < 8; i++) begin
      ref_c[i]  = 16'h0;
      refb_c[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      ifc.wa_en       = 1'($urandom_range(0, 1));
      ifc.wa_addr     = 3'($urandom_range(0, 7));
      ifc.wa_data     = 16'($urandom);
      ifc.wb_en       = 1'($urandom_range(0, 1));
      ifc.wb_addr     = 3'($urandom_range(0, 7));
      ifc.wb_data     = 16'($urandom);
      ifc.sb_set_en   = 1'($urandom_range(0, 1));
      ifc.sb_set_addr = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) ra[p] = 3'($urandom_range(0, 7));
      ifc.rd_addr = {ra[2], ra[1], ra[0]};
      for (int p = 0; p < 3; p++) begin
        if (ra[p] == 3'd0) begin
          ed = 16'h0;
          eb = 1'b0;
        end else begin
          if (ifc.wa_en && ifc.wa_addr == ra[p])      ed = ifc.wa_data;
          else if (ifc.wb_en && ifc.wb_addr == ra[p]) ed = ifc.wb_data;
          else                                        ed = ref_c[ra[p]];
          if (ifc.wb_en && ifc.wb_addr == ra[p] &&
              !(ifc.sb_set_en && ifc.sb_set_addr == ra[p])) eb = 1'b0;
          else                                              eb = refb_c[ra[p]];
        end
        exp($sformatf("rand_c%0d_p%0d_data", cyc, p), {16'b0, ed});
        exp($sformatf("rand_c%0d_p%0d_busy", cyc, p), {31'b0, eb});
      end
      #1;
      for (int p = 0; p < 3; p++) begin
        chk(dc(p));
        chk(bc(p));
      end
      // model state at the coming rising edge
      if (ifc.wb_en && ifc.wb_addr != 3'd0) ref_c[ifc.wb_addr] = ifc.wb_data;
      if (ifc.wa_en && ifc.wa_addr != 3'd0) ref_c[ifc.wa_addr] = ifc.wa_data;
      if (ifc.wb_en && ifc.wb_addr != 3'd0) refb_c[ifc.wb_addr] = 1'b0;
      if (ifc.sb_set_en && ifc.sb_set_addr != 3'd0) refb_c[ifc.sb_set_addr] = 1'b1;
    end
    @(negedge clk);
    idle_c();

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_mp
`default_nettype wire
